// File: rtl/misao_pkg.sv
// Shared types and width defaults for the MISA-O memory arbiter slice.
package misao_pkg;

   localparam int MISAO_ADDR_W = 15;
   localparam int MISAO_DATA_W = 8;

   // Owner of the read whose byte returns on mem_data_in next cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FRD  = 2'd1,
      S_DRD  = 2'd2
   } owner_e;

endpackage

// File: rtl/misao_mem_arbiter_if.sv
// Bundle of fetch, data and memory-pin signals around the arbiter.
// slave: the arbiter's view; master: the core + memory environment.
interface misao_mem_arbiter_if
   import misao_pkg::*;
#(
   parameter int ADDR_W = MISAO_ADDR_W,
   parameter int DATA_W = MISAO_DATA_W
) ();

   // Fetch requester
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_flush;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;

   // Data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   // Memory pins
   logic              mem_enable_read;
   logic              mem_enable_write;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_out;
   logic [DATA_W-1:0] mem_data_in;

   modport slave (
      input  f_req, f_addr, f_flush,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_data_in,
      output f_gnt, f_rvalid, f_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out
   );

   modport master (
      output f_req, f_addr, f_flush,
      output d_req, d_we, d_addr, d_wdata,
      output mem_data_in,
      input  f_gnt, f_rvalid, f_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_enable_read, mem_enable_write, mem_rw, mem_addr, mem_data_out
   );

endinterface

// File: rtl/misao_starve_guard.sv
// Counts consecutive data grants taken while a fetch is waiting, and
// raises force_fetch once the data side has had its full burst.
module misao_starve_guard #(
   parameter int DATA_BURST_MAX = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic fetch_elig,
   input  logic data_gnt,
   input  logic fetch_gnt,
   output logic force_fetch
);

   localparam int CNT_W = (DATA_BURST_MAX < 1) ? 1 : $clog2(DATA_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BURST_MAX);

   logic [CNT_W-1:0] burst_cnt;

   // Saturating burst counter; any break in fetch eligibility restarts it.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (fetch_gnt || !fetch_elig) begin
         burst_cnt <= '0;
      end else if (data_gnt && (burst_cnt != CNT_MAX)) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end

   assign force_fetch = (burst_cnt == CNT_MAX);

endmodule

// File: rtl/misao_mem_arbiter.sv
// Shares the single byte-wide memory port between instruction fetch and
// the data unit: one access per cycle, response routed to its owner.
module misao_mem_arbiter
   import misao_pkg::*;
#(
   parameter int ADDR_W         = MISAO_ADDR_W,
   parameter int DATA_W         = MISAO_DATA_W,
   parameter int DATA_BURST_MAX = 2
) (
   input logic                 clk,
   input logic                 rst,
   misao_mem_arbiter_if.slave  bus
);

   logic              fetch_elig;
   logic              force_fetch;
   logic              fetch_gnt;
   logic              data_gnt;
   logic              data_rd_gnt;
   logic              data_wr_gnt;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] wdata_mux;
   logic              f_rvalid;
   logic              d_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic [DATA_W-1:0] d_rdata;
   owner_e            state;
   owner_e            state_next;

   assign fetch_elig = bus.f_req && !bus.f_flush;

   misao_starve_guard #(
      .DATA_BURST_MAX (DATA_BURST_MAX)
   ) u_starve_guard (
      .clk         (clk),
      .rst         (rst),
      .fetch_elig  (fetch_elig),
      .data_gnt    (data_gnt),
      .fetch_gnt   (fetch_gnt),
      .force_fetch (force_fetch)
   );

   // Grant selection: data wins unless a waiting fetch has used up its patience.
   // Grants are held low during reset so nothing reaches the memory pins.
   // NOTE: every signal written in always_comb gets a default first, so no latch.
   always_comb begin
      fetch_gnt = 1'b0;
      data_gnt  = 1'b0;
      if (!rst) begin
         if (fetch_elig && (force_fetch || !bus.d_req)) begin
            fetch_gnt = 1'b1;
         end else if (bus.d_req) begin
            data_gnt = 1'b1;
         end
      end
   end

   assign data_rd_gnt = data_gnt && !bus.d_we;
   assign data_wr_gnt = data_gnt && bus.d_we;

   // Memory address/data mux; bus is driven to zero when nothing is issued.
   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      if (fetch_gnt) begin
         addr_mux = bus.f_addr;
      end else if (data_gnt) begin
         addr_mux = bus.d_addr;
         if (bus.d_we) begin
            wdata_mux = bus.d_wdata;
         end
      end
   end

   // Read-owner state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next owner follows this cycle's grant only; writes leave nothing in flight.
   always_comb begin
      state_next = S_IDLE;
      if (fetch_gnt) begin
         state_next = S_FRD;
      end else if (data_rd_gnt) begin
         state_next = S_DRD;
      end
   end

   // Response routing; a flush in the return cycle kills the fetch byte.
   always_comb begin
      f_rvalid = 1'b0;
      d_rvalid = 1'b0;
      unique case (state)
         S_FRD:   f_rvalid = !bus.f_flush;
         S_DRD:   d_rvalid = 1'b1;
         default: ;
      endcase
      f_rdata = f_rvalid ? bus.mem_data_in : '0;
      d_rdata = d_rvalid ? bus.mem_data_in : '0;
   end

   assign bus.f_gnt            = fetch_gnt;
   assign bus.d_gnt            = data_gnt;
   assign bus.f_rvalid         = f_rvalid;
   assign bus.f_rdata          = f_rdata;
   assign bus.d_rvalid         = d_rvalid;
   assign bus.d_rdata          = d_rdata;
   assign bus.mem_enable_read  = fetch_gnt || data_rd_gnt;
   assign bus.mem_enable_write = data_wr_gnt;
   assign bus.mem_rw           = data_wr_gnt;
   assign bus.mem_addr         = addr_mux;
   assign bus.mem_data_out     = wdata_mux;

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Directed bench for misao_mem_arbiter with a registered-read byte memory model.
module tb_misao_mem_arbiter;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   misao_mem_arbiter_if bus ();

   misao_mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory model: 256 bytes, read data registered one cycle after strobe.
   logic [7:0]  mem [0:255];
   logic [7:0]  rd_q = 8'h00;
   logic        pre_we = 1'b0;
   logic [7:0]  pre_addr = 8'h00;
   logic [7:0]  pre_data = 8'h00;

   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (bus.mem_enable_write) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_data_out;
      end
      if (bus.mem_enable_read) begin
         rd_q <= mem[bus.mem_addr[7:0]];
      end
   end

   assign bus.mem_data_in = rd_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_fetch(input logic req, input logic [14:0] addr, input logic flush);
      bus.f_req   = req;
      bus.f_addr  = addr;
      bus.f_flush = flush;
   endtask

   task automatic set_data(input logic req, input logic we, input logic [14:0] addr,
                           input logic [7:0] wdata);
      bus.d_req   = req;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] pre_a [8] = '{8'h02, 8'h20, 8'h21, 8'h22, 8'h04, 8'h08, 8'h30, 8'h40};
      logic [7:0] pre_d [8] = '{8'h34, 8'h11, 8'h22, 8'h33, 8'h44, 8'h88, 8'h5A, 8'hC3};
      int         pat_d [6] = '{1, 1, 0, 1, 1, 0};

      // Reset with both requesters active: everything must stay low.
      rst = 1'b1;
      set_fetch(1'b1, 15'h0002, 1'b0);
      set_data(1'b1, 1'b1, 15'h0010, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         pre_we   = 1'b1;
         pre_addr = pre_a[i];
         pre_data = pre_d[i];
         tick();
      end
      pre_we = 1'b0;
      #1;
      check("rst f_gnt",       bus.f_gnt, 0);
      check("rst d_gnt",       bus.d_gnt, 0);
      check("rst mem_en_rd",   bus.mem_enable_read, 0);
      check("rst mem_en_wr",   bus.mem_enable_write, 0);
      check("rst mem_rw",      bus.mem_rw, 0);
      check("rst mem_addr",    bus.mem_addr, 0);
      check("rst mem_dout",    bus.mem_data_out, 0);
      check("rst f_rvalid",    bus.f_rvalid, 0);
      check("rst d_rvalid",    bus.d_rvalid, 0);
      check("rst f_rdata",     bus.f_rdata, 0);
      check("rst d_rdata",     bus.d_rdata, 0);

      tick();
      rst = 1'b0;
      set_fetch(1'b0, 15'h0000, 1'b0);
      set_data(1'b0, 1'b0, 15'h0000, 8'h00);
      #1;
      check("idle mem_addr", bus.mem_addr, 0);
      check("idle f_gnt",    bus.f_gnt, 0);
      check("idle d_gnt",    bus.d_gnt, 0);

      // 1: plain fetch read
      tick();
      set_fetch(1'b1, 15'h0002, 1'b0);
      #1;
      check("t1 f_gnt",    bus.f_gnt, 1);
      check("t1 d_gnt",    bus.d_gnt, 0);
      check("t1 mem_en_rd", bus.mem_enable_read, 1);
      check("t1 mem_addr", bus.mem_addr, 15'h0002);
      tick();
      set_fetch(1'b0, 15'h0000, 1'b0);
      #1;
      check("t1 f_rvalid", bus.f_rvalid, 1);
      check("t1 f_rdata",  bus.f_rdata, 8'h34);
      check("t1 d_rvalid", bus.d_rvalid, 0);
      tick();
      #1;
      check("t1 f_rvalid drop", bus.f_rvalid, 0);
      check("t1 f_rdata zero",  bus.f_rdata, 0);

      // 2: data write then read-back
      tick();
      set_data(1'b1, 1'b1, 15'h0010, 8'hA5);
      #1;
      check("t2 d_gnt wr",    bus.d_gnt, 1);
      check("t2 mem_en_wr",   bus.mem_enable_write, 1);
      check("t2 mem_rw",      bus.mem_rw, 1);
      check("t2 mem_en_rd",   bus.mem_enable_read, 0);
      check("t2 mem_addr",    bus.mem_addr, 15'h0010);
      check("t2 mem_dout",    bus.mem_data_out, 8'hA5);
      tick();
      set_data(1'b1, 1'b0, 15'h0010, 8'h00);
      #1;
      check("t2 no wr resp",  bus.d_rvalid, 0);
      check("t2 d_gnt rd",    bus.d_gnt, 1);
      check("t2 rd mem_rw",   bus.mem_rw, 0);
      check("t2 rd mem_dout", bus.mem_data_out, 0);
      tick();
      set_data(1'b0, 1'b0, 15'h0000, 8'h00);
      #1;
      check("t2 d_rvalid",    bus.d_rvalid, 1);
      check("t2 d_rdata",     bus.d_rdata, 8'hA5);

      // 3: contention, expected grant order D,D,F,D,D,F
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i < 6) begin
            set_fetch(1'b1, 15'h0030, 1'b0);
            set_data(1'b1, 1'b0, 15'h0040, 8'h00);
         end else begin
            set_fetch(1'b0, 15'h0000, 1'b0);
            set_data(1'b0, 1'b0, 15'h0000, 8'h00);
         end
         #1;
         if (i < 6) begin
            check($sformatf("t3 d_gnt c%0d", i), bus.d_gnt, pat_d[i]);
            check($sformatf("t3 f_gnt c%0d", i), bus.f_gnt, 1 - pat_d[i]);
            check($sformatf("t3 addr c%0d", i), bus.mem_addr,
                  (pat_d[i] == 1) ? 32'h40 : 32'h30);
         end
         if (i > 0) begin
            check($sformatf("t3 d_rvalid c%0d", i), bus.d_rvalid, pat_d[i-1]);
            check($sformatf("t3 f_rvalid c%0d", i), bus.f_rvalid, 1 - pat_d[i-1]);
            if (pat_d[i-1] == 1) check($sformatf("t3 d_rdata c%0d", i), bus.d_rdata, 8'hC3);
            else                 check($sformatf("t3 f_rdata c%0d", i), bus.f_rdata, 8'h5A);
         end
      end

      // 4: flush kills the in-flight fetch and blocks a new grant that cycle
      tick();
      set_fetch(1'b1, 15'h0004, 1'b0);
      #1;
      check("t4 f_gnt N", bus.f_gnt, 1);
      tick();
      set_fetch(1'b1, 15'h0008, 1'b1);
      #1;
      check("t4 f_rvalid flushed", bus.f_rvalid, 0);
      check("t4 f_rdata flushed",  bus.f_rdata, 0);
      check("t4 f_gnt blocked",    bus.f_gnt, 0);
      check("t4 mem_en_rd blocked", bus.mem_enable_read, 0);
      tick();
      set_fetch(1'b1, 15'h0008, 1'b0);
      #1;
      check("t4 f_gnt regrant", bus.f_gnt, 1);
      check("t4 regrant addr",  bus.mem_addr, 15'h0008);
      check("t4 no stale resp", bus.f_rvalid, 0);
      tick();
      set_fetch(1'b0, 15'h0000, 1'b0);
      #1;
      check("t4 f_rvalid", bus.f_rvalid, 1);
      check("t4 f_rdata",  bus.f_rdata, 8'h88);

      // 5: reset while a data read is in flight
      tick();
      set_data(1'b1, 1'b0, 15'h0020, 8'h00);
      #1;
      check("t5 d_gnt", bus.d_gnt, 1);
      tick();
      set_data(1'b0, 1'b0, 15'h0000, 8'h00);
      set_fetch(1'b1, 15'h0002, 1'b0);
      rst = 1'b1;
      #1;
      check("t5 rst d_rvalid", bus.d_rvalid, 0);
      check("t5 rst d_rdata",  bus.d_rdata, 0);
      check("t5 rst f_gnt",    bus.f_gnt, 0);
      check("t5 rst mem_en_rd", bus.mem_enable_read, 0);
      check("t5 rst mem_addr", bus.mem_addr, 0);
      tick();
      rst = 1'b0;
      set_fetch(1'b0, 15'h0000, 1'b0);
      #1;
      check("t5 post d_rvalid", bus.d_rvalid, 0);
      tick();
      set_fetch(1'b1, 15'h0002, 1'b0);
      #1;
      check("t5 post f_gnt",    bus.f_gnt, 1);
      check("t5 post mem_addr", bus.mem_addr, 15'h0002);
      check("t5 post d_rvalid2", bus.d_rvalid, 0);
      tick();
      set_fetch(1'b0, 15'h0000, 1'b0);
      #1;
      check("t5 post f_rvalid", bus.f_rvalid, 1);
      check("t5 post f_rdata",  bus.f_rdata, 8'h34);

      // 6: back-to-back data reads
      tick();
      set_data(1'b1, 1'b0, 15'h0020, 8'h00);
      #1;
      check("t6 gnt0", bus.d_gnt, 1);
      tick();
      set_data(1'b1, 1'b0, 15'h0021, 8'h00);
      #1;
      check("t6 gnt1",    bus.d_gnt, 1);
      check("t6 rvalid0", bus.d_rvalid, 1);
      check("t6 rdata0",  bus.d_rdata, 8'h11);
      tick();
      set_data(1'b1, 1'b0, 15'h0022, 8'h00);
      #1;
      check("t6 gnt2",    bus.d_gnt, 1);
      check("t6 rvalid1", bus.d_rvalid, 1);
      check("t6 rdata1",  bus.d_rdata, 8'h22);
      tick();
      set_data(1'b0, 1'b0, 15'h0000, 8'h00);
      #1;
      check("t6 rvalid2", bus.d_rvalid, 1);
      check("t6 rdata2",  bus.d_rdata, 8'h33);
      tick();
      #1;
      check("t6 rvalid end", bus.d_rvalid, 0);
      check("t6 rdata end",  bus.d_rdata, 0);

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
